// File: rtl/seq_div_16bit.sv
// Multi-cycle signed 16-bit restoring divider with saturating results.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module seq_div_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [16:0] p;
    logic [15:0] q;
    logic [15:0] dvsr;
    logic        q_neg, r_neg, dbz;

    logic        accept, iterate, finish;
    logic        zero_div, overflow, fast;
    logic [15:0] dividend_mag, divisor_mag;
    logic [16:0] p_sh;
    logic [15:0] q_sh;
    logic [17:0] trial;

    assign zero_div     = (divisor == 16'h0000);
    assign overflow     = (dividend == 16'h8000) && (divisor == 16'hFFFF);
    assign fast         = zero_div || overflow;
    assign dividend_mag = dividend[15] ? (16'h0000 - dividend) : dividend;
    assign divisor_mag  = divisor[15]  ? (16'h0000 - divisor)  : divisor;

    assign p_sh  = {p[15:0], q[15]};
    assign q_sh  = {q[14:0], 1'b0};
    assign trial = {1'b0, p_sh} - {2'b00, dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A request is refused while the done pulse is still up, so the earliest
    // accepted start is the cycle after done.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = fast ? FIN : CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (count == 5'd15) state_next = FIN;
            end
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Fast paths preload Q/P with the final result so FIN's fix-up is shared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 5'd0;
            p           <= 17'd0;
            q           <= 16'd0;
            dvsr        <= 16'd0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            busy <= (state_next != IDLE) || finish;
            if (accept) begin
                count <= 5'd0;
                dvsr  <= divisor_mag;
                dbz   <= zero_div;
                if (zero_div) begin
                    q     <= dividend[15] ? 16'h8000 : 16'h7FFF;
                    p     <= {1'b0, dividend};
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else if (overflow) begin
                    q     <= 16'h7FFF;
                    p     <= 17'd0;
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end else begin
                    q     <= dividend_mag;
                    p     <= 17'd0;
                    q_neg <= dividend[15] ^ divisor[15];
                    r_neg <= dividend[15];
                end
            end
            if (iterate) begin
                count <= count + 5'd1;
                p     <= trial[17] ? p_sh : trial[16:0];
                q     <= {q_sh[15:1], ~trial[17]};
            end
            if (finish) begin
                quotient    <= q_neg ? (16'h0000 - q) : q;
                remainder   <= r_neg ? (16'h0000 - p[15:0]) : p[15:0];
                div_by_zero <= dbz;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_16bit.sv
// Directed-vector and random reference-model bench for seq_div_16bit,
// covering latency, sign handling, saturation, reset abandonment and start filtering.
module tb_seq_div_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend, divisor;
    logic [15:0] quotient, remainder;
    logic        busy, done, div_by_zero;

    int checks     = 0;
    int fails      = 0;
    int done_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    seq_div_16bit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_count++;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for idle, pulses start for one edge, then counts edges until done.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, output int lat);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("[TB] FAIL timeout: no done for %0h/%0h after %0d cycles", a, b, lat);
        end
    endtask

    function automatic void refDiv(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dbz, output int lat);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dbz = 1'b0;
        lat = 17;
        if (sb == 0) begin
            q   = (sa >= 0) ? 16'h7FFF : 16'h8000;
            r   = a;
            dbz = 1'b1;
            lat = 1;
        end else if (sa == -32768 && sb == -1) begin
            q   = 16'h7FFF;
            r   = 16'h0000;
            lat = 1;
        end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end
    endfunction

    initial begin
        int          lat;
        int          d0;
        logic [15:0] ea, eb, eq, er;
        logic        edbz;
        int          elat;

        vecs[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
        vecs[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 17};
        vecs[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 17};
        vecs[3]  = '{16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 17};
        vecs[4]  = '{16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0, 17};
        vecs[5]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'd0,    1'b0, 1};
        vecs[6]  = '{16'h7FFF, 16'h8000, 16'd0,    16'h7FFF, 1'b0, 17};
        vecs[7]  = '{16'd5,    16'd0,    16'h7FFF, 16'd5,    1'b1, 1};
        vecs[8]  = '{16'hFFFB, 16'd0,    16'h8000, 16'hFFFB, 1'b1, 1};
        vecs[9]  = '{16'd9,    16'd3,    16'd3,    16'd0,    1'b0, 17};
        vecs[10] = '{16'h8000, 16'h8000, 16'd1,    16'd0,    1'b0, 17};
        vecs[11] = '{16'h8000, 16'd7,    16'hEDB7, 16'hFFFF, 1'b0, 17};
        vecs[12] = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 17};
        vecs[13] = '{16'hFFFF, 16'd2,    16'd0,    16'hFFFF, 1'b0, 17};

        rst_n = 1'b0;
        start = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        #12;
        checkOutput("reset quotient",  int'(quotient),    0);
        checkOutput("reset remainder", int'(remainder),   0);
        checkOutput("reset busy",      int'(busy),        0);
        checkOutput("reset done",      int'(done),        0);
        checkOutput("reset dbz",       int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d quotient", i),  int'(quotient),    int'(vecs[i].q));
            checkOutput($sformatf("vec%0d remainder", i), int'(remainder),   int'(vecs[i].r));
            checkOutput($sformatf("vec%0d dbz", i),       int'(div_by_zero), int'(vecs[i].dbz));
            checkOutput($sformatf("vec%0d latency", i),   lat,               vecs[i].lat);
            checkOutput($sformatf("vec%0d busy", i),      int'(busy),        1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done pulse", i), int'(done),       0);
        end

        // Reset at E5 of 100/7 after a completed division: everything clears, no done.
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        d0 = done_count;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset quotient",  int'(quotient),    0);
        checkOutput("midreset remainder", int'(remainder),   0);
        checkOutput("midreset busy",      int'(busy),        0);
        checkOutput("midreset done",      int'(done),        0);
        checkOutput("midreset dbz",       int'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abandoned done count", done_count - d0, 0);
        checkOutput("abandoned busy",       int'(busy),      0);
        applyStimulus(16'd100, 16'd7, lat);
        checkOutput("post-reset quotient",  int'(quotient),  14);
        checkOutput("post-reset remainder", int'(remainder), 2);
        checkOutput("post-reset latency",   lat,             17);

        // Start pulses at E3 and in the done cycle must be ignored.
        repeat (3) @(posedge clk);
        d0 = done_count;
        @(negedge clk);
        dividend = 16'd20;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("ignore-start latency", lat, 17);
        @(negedge clk);
        dividend = 16'd99;
        divisor  = 16'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("ignore-start done count", done_count - d0, 1);
        checkOutput("ignore-start quotient",   int'(quotient),  6);
        checkOutput("ignore-start remainder",  int'(remainder), 2);
        checkOutput("ignore-start busy",       int'(busy),      0);

        for (int n = 0; n < 2000; n++) begin
            ea = 16'($urandom);
            eb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: eb = 16'd0;
                1: begin ea = 16'h8000; eb = 16'hFFFF; end
                2: eb = 16'($urandom_range(1, 20));
                3: eb = 16'hFFFF;
                default: ;
            endcase
            refDiv(ea, eb, eq, er, edbz, elat);
            applyStimulus(ea, eb, lat);
            checkOutput($sformatf("rand %0h/%0h quotient", ea, eb),  int'(quotient),    int'(eq));
            checkOutput($sformatf("rand %0h/%0h remainder", ea, eb), int'(remainder),   int'(er));
            checkOutput($sformatf("rand %0h/%0h dbz", ea, eb),       int'(div_by_zero), int'(edbz));
            checkOutput($sformatf("rand %0h/%0h latency", ea, eb),   lat,               elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
